alu_64: RTL and testbench

ALU_64 -- requirements
Module: alu_64

---
 rtl/alu_64.sv | 128 ++++++++++++
 tb/tb_alu_64.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_64.sv
// 64-bit add/subtract with signed and unsigned compare flags.
// Latency: one clock from input sample to registered outputs.
// Backpressure: none; a new operation is accepted on every rising edge.

module alu_64_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        ovf
);
    logic [63:0] p;
    logic [63:0] g;
    logic [15:0] grp_p;
    logic [15:0] grp_g;
    logic        cy;
    logic        cb;
    logic        c_msb;

    assign p = a ^ b;
    assign g = a & b;

    // Two-level carry: 4-bit lookahead groups, group carries chained.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        sum   = '0;
        cy    = cin;
        cb    = cin;
        c_msb = 1'b0;
        for (int k = 0; k < 16; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            cb = cy;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ cb;
                if ((4*k + j) == 63) begin
                    c_msb = cb;
                end
                cb = g[4*k+j] | (p[4*k+j] & cb);
            end
            cy = grp_g[k] | (grp_p[k] & cy);
        end
        cout = cy;
        ovf  = c_msb ^ cy;
    end
endmodule

module alu_64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        SUM_SUB,
    output logic [63:0] result,
    output logic        equal,
    output logic        not_equal,
    output logic        lesser_than,
    output logic        greater_or_equal,
    output logic        unsigned_lesser,
    output logic        unsigned_greater_equal
);
    logic [63:0] res_b;
    logic [63:0] res_sum;
    logic        res_cout;
    logic        res_ovf;

    logic [63:0] cmp_diff;
    logic        cmp_cout;
    logic        cmp_ovf;

    logic        eq_nxt;
    logic        lt_nxt;
    logic        ult_nxt;

    assign res_b = SUM_SUB ? ~B : B;

    alu_64_adder u_res_adder (
        .a    (A),
        .b    (res_b),
        .cin  (SUM_SUB),
        .sum  (res_sum),
        .cout (res_cout),
        .ovf  (res_ovf)
    );

    // Flags come from their own A-B path so they never depend on SUM_SUB.
    alu_64_adder u_cmp_adder (
        .a    (A),
        .b    (~B),
        .cin  (1'b1),
        .sum  (cmp_diff),
        .cout (cmp_cout),
        .ovf  (cmp_ovf)
    );

    assign eq_nxt  = ~|cmp_diff;
    assign lt_nxt  = cmp_diff[63] ^ cmp_ovf;
    assign ult_nxt = ~cmp_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result                 <= '0;
            equal                  <= 1'b0;
            not_equal              <= 1'b0;
            lesser_than            <= 1'b0;
            greater_or_equal       <= 1'b0;
            unsigned_lesser        <= 1'b0;
            unsigned_greater_equal <= 1'b0;
        end else begin
            result                 <= res_sum;
            equal                  <= eq_nxt;
            not_equal              <= ~eq_nxt;
            lesser_than            <= lt_nxt;
            greater_or_equal       <= ~lt_nxt;
            unsigned_lesser        <= ult_nxt;
            unsigned_greater_equal <= ~ult_nxt;
        end
    end

    // Carry-out and overflow of the result path are intentionally dropped.
    logic unused_res;
    assign unused_res = res_cout ^ res_ovf;
endmodule

// File: tb/tb_alu_64.sv
module tb_alu_64;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        sum_sub;
    logic [63:0] result;
    logic        equal;
    logic        not_equal;
    logic        lesser_than;
    logic        greater_or_equal;
    logic        unsigned_lesser;
    logic        unsigned_greater_equal;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] res;
        logic [5:0]  flg;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_64 dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .A                      (a),
        .B                      (b),
        .SUM_SUB                (sum_sub),
        .result                 (result),
        .equal                  (equal),
        .not_equal              (not_equal),
        .lesser_than            (lesser_than),
        .greater_or_equal       (greater_or_equal),
        .unsigned_lesser        (unsigned_lesser),
        .unsigned_greater_equal (unsigned_greater_equal)
    );

    // Flag order: {eq, ne, lt, ge, ult, uge}
    function automatic logic [5:0] dut_flags();
        return {equal, not_equal, lesser_than, greater_or_equal,
                unsigned_lesser, unsigned_greater_equal};
    endfunction

    task automatic ref_model(input logic [63:0] ra, input logic [63:0] rb, input logic rs,
                             output logic [63:0] res, output logic [5:0] flg);
        logic eq, lt, ult;
        res = rs ? (ra - rb) : (ra + rb);
        eq  = (ra == rb);
        lt  = ($signed(ra) < $signed(rb));
        ult = (ra < rb);
        flg = {eq, !eq, lt, !lt, ult, !ult};
    endtask

    task automatic check(input string name, input logic [63:0] er, input logic [5:0] ef);
        n_cmp++;
        if (result !== er) begin
            n_bad++;
            $display("FAIL %s result: got %h expected %h", name, result, er);
        end
        n_cmp++;
        if (dut_flags() !== ef) begin
            n_bad++;
            $display("FAIL %s flags: got %b expected %b", name, dut_flags(), ef);
        end
    endtask

    task automatic add_vec(input logic [63:0] va, input logic [63:0] vb, input logic vs,
                           input logic [63:0] vr, input logic [5:0] vf);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.flg = vf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [63:0] da, input logic [63:0] db, input logic ds);
        @(negedge clk);
        a = da; b = db; sum_sub = ds;
    endtask

    initial begin
        logic [63:0] ra, rb, er;
        logic [5:0]  ef;
        logic        rs;
        int          mode;

        // Hand-derived expectations; flags {eq, ne, lt, ge, ult, uge}
        add_vec(64'd10,  64'd10,  1'b0, 64'd20,                  6'b100101);
        add_vec(64'd30,  -64'd10, 1'b0, 64'd20,                  6'b010110);
        add_vec(64'd30,  64'd40,  1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 6'b011010);
        add_vec(64'd40,  -64'd30, 1'b1, 64'd70,                  6'b010110);
        add_vec(64'd7,   64'd7,   1'b0, 64'd14,                  6'b100101);
        add_vec(-64'd7,  -64'd7,  1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 6'b100101);
        add_vec(64'd7,   64'd8,   1'b0, 64'd15,                  6'b011010);
        add_vec(64'd7,   -64'd8,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010110);
        add_vec(64'd5,   64'd10,  1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 6'b011010);
        add_vec(-64'd15, -64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 6'b011010);
        add_vec(64'd15,  64'd10,  1'b1, 64'd5,                   6'b010101);
        add_vec(-64'd5,  -64'd10, 1'b1, 64'd5,                   6'b010101);
        add_vec(-64'd10, -64'd10, 1'b1, 64'd0,                   6'b100101);
        add_vec(64'd80,  -64'd8,  1'b0, 64'd72,                  6'b010110);
        add_vec(-64'd9,  64'd80,  1'b0, 64'd71,                  6'b011001);
        add_vec(64'd9,   64'd8,   1'b1, 64'd1,                   6'b010101);
        add_vec(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 6'b011001);
        add_vec(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 6'b010101);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,                   6'b011001);

        // Reset held from time zero with nonzero inputs present
        rst_n = 1'b0; a = 64'd5; b = 64'd3; sum_sub = 1'b0;
        #2;
        check("reset_t0", 64'd0, 6'b000000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 64'd0, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", 64'd0, 6'b000000);
        @(posedge clk);
        #1;
        check("first_after_release", 64'd8, 6'b010101);

        // Directed table, one operation per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sub);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg);
        end

        // Outputs must hold until the next edge after inputs change
        drive(64'd100, 64'd1, 1'b0);
        @(posedge clk);
        #1;
        check("hold_a", 64'd101, 6'b010101);
        drive(64'd3, 64'd4, 1'b1);
        #1;
        check("hold_b", 64'd101, 6'b010101);

        // Mid-operation asynchronous reset discards the pending result
        @(posedge clk);
        #1;
        check("pre_reset", 64'hFFFF_FFFF_FFFF_FFFF, 6'b011010);
        drive(64'd50, 64'd20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'd0, 6'b000000);
        @(posedge clk);
        #1;
        check("reset_over_edge", 64'd0, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease_before_edge", 64'd0, 6'b000000);
        @(posedge clk);
        #1;
        check("rerelease_first", 64'd70, 6'b010101);

        // Randomised traffic against the arithmetic reference model
        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 3);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                rb = ra;
            end else if (mode == 1) begin
                ra[63] = $urandom_range(0, 1) == 1;
                ra[62:0] = ($urandom_range(0, 1) == 1) ? '1 : '0;
                rb = 64'($urandom_range(0, 3)) - 64'd1;
            end
            ref_model(ra, rb, rs, er, ef);
            drive(ra, rb, rs);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), er, ef);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
